// File: rtl/ts_merge_sched_pkg.sv
// Shared constants, FSM encoding and TS RAM address packing for the TS merge scheduler.
package ts_merge_sched_pkg;

  localparam int unsigned TS_PKT_BYTES = 188;
  localparam int unsigned TS_WORDS     = 12;
  localparam int unsigned SLOT_BITS    = 6;
  localparam int unsigned WORD_BITS    = 4;
  localparam int unsigned CH_BITS      = 3;
  localparam int unsigned CNT_BITS     = 7;
  localparam int unsigned SLOT_CNT     = 64;
  localparam int unsigned ADDR_BITS    = CH_BITS + SLOT_BITS + WORD_BITS;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StFetch,
    StSend,
    StGap
  } ts_state_e;

  // RAM address layout: {channel, slot, word}.
  function automatic logic [ADDR_BITS-1:0] ts_addr_pack(input logic [CH_BITS-1:0]   ch,
                                                        input logic [SLOT_BITS-1:0] slot,
                                                        input logic [WORD_BITS-1:0] word);
    return {ch, slot, word};
  endfunction

endpackage

// File: rtl/ts_ch_cnt.sv
// Per-channel bookkeeping: pending packet count, read slot pointer and sticky overflow flag.
module ts_ch_cnt
  import ts_merge_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_done,
  input  logic                 rd_done,
  input  logic                 ovf_clr,
  output logic [CNT_BITS-1:0]  count,
  output logic [SLOT_BITS-1:0] rd_ptr,
  output logic                 ovf
);

  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(SLOT_CNT);

  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [SLOT_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_set;

  // Next count/pointer/flag; a write and a read completing together cancel (no overflow).
  always_comb begin
    count_d  = count_q;
    ovf_set  = 1'b0;
    rd_ptr_d = rd_done ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_done, rd_done})
      2'b10: begin
        if (count_q == CntMax) ovf_set = 1'b1;
        else                   count_d = count_q + 1'b1;
      end
      2'b01: begin
        if (count_q != '0) count_d = count_q - 1'b1;
      end
      default: ;
    endcase
    // A new overflow wins over a simultaneous clear.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count  = count_q;
  assign rd_ptr = rd_ptr_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/ts_merge_sched.sv
// Round-robin merge of NCH TS channels from a shared RAM into one byte stream.
module ts_merge_sched
  import ts_merge_sched_pkg::*;
#(
  parameter int unsigned NCH    = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned IPG    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       pkt_wr_done,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 ovf_clr,
  output logic                 ts_ram_rd,
  output logic [ADDR_BITS-1:0] ts_ram_raddr,
  input  logic [127:0]         ts_ram_rdata,
  output logic [7:0]           ts_dout,
  output logic                 ts_dout_en,
  output logic                 ts_dout_sop,
  output logic [CH_BITS-1:0]   ts_dout_ch,
  output logic [NCH-1:0]       ovf
);

  // Prefetch is timed so the next word lands exactly on the last byte of the current one.
  localparam logic [WORD_BITS-1:0] PrefetchAt = WORD_BITS'(15 - RD_LAT);
  localparam logic [WORD_BITS-1:0] LastWord   = WORD_BITS'(TS_WORDS - 1);
  localparam logic [7:0]           LastByte   = 8'(TS_PKT_BYTES - 1);
  localparam logic [3:0]           LatLast    = 4'(RD_LAT);
  localparam logic [CH_BITS-1:0]   LastInit   = CH_BITS'(NCH - 1);
  // ARB and FETCH already contribute RD_LAT+2 idle cycles; GAP only pads up to IPG.
  localparam int unsigned          GapCycles  = (IPG > RD_LAT + 2) ? IPG - RD_LAT - 2 : 0;
  localparam logic [7:0]           GapLast    = 8'(GapCycles - 1);

  ts_state_e            state_q, state_d;
  logic [CH_BITS-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_BITS-1:0]   last_q, last_d;
  logic [7:0]           byte_cnt_q, byte_cnt_d;
  logic [3:0]           lat_cnt_q, lat_cnt_d;
  logic [7:0]           gap_cnt_q, gap_cnt_d;
  logic [127:0]         shreg_q, shreg_d;

  logic [CNT_BITS-1:0]  ch_cnt [NCH];
  logic [SLOT_BITS-1:0] ch_rd_ptr [NCH];
  logic [NCH-1:0]       elig;
  logic [NCH-1:0]       pkt_done;
  logic                 send_last;
  logic [CH_BITS-1:0]   grant;
  logic                 grant_vld;
  logic [WORD_BITS-1:0] rd_word;

  assign send_last = (state_q == StSend) && (byte_cnt_q == LastByte);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign elig[gi]     = ch_en[gi] && (ch_cnt[gi] != '0);
    assign pkt_done[gi] = send_last && (cur_ch_q == CH_BITS'(gi));

    ts_ch_cnt u_ch_cnt (
      .clk     (clk),
      .rst     (rst),
      .wr_done (pkt_wr_done[gi]),
      .rd_done (pkt_done[gi]),
      .ovf_clr (ovf_clr),
      .count   (ch_cnt[gi]),
      .rd_ptr  (ch_rd_ptr[gi]),
      .ovf     (ovf[gi])
    );
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    logic [CH_BITS-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = 1; i <= int'(NCH); i++) begin
      idx = CH_BITS'((int'(last_q) + i) % int'(NCH));
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // Scheduler FSM next state and datapath updates.
  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shreg_d    = shreg_q;
    unique case (state_q)
      StIdle: begin
        if (|elig) state_d = StArb;
      end
      StArb: begin
        if (grant_vld) begin
          cur_ch_d  = grant;
          last_d    = grant;
          lat_cnt_d = '0;
          state_d   = StFetch;
        end else begin
          state_d = StIdle;
        end
      end
      StFetch: begin
        if (lat_cnt_q == LatLast) begin
          shreg_d    = ts_ram_rdata;
          byte_cnt_d = '0;
          state_d    = StSend;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StSend: begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (byte_cnt_q[3:0] == 4'hF) shreg_d = ts_ram_rdata;
        else                         shreg_d = {shreg_q[119:0], 8'h00};
        if (byte_cnt_q == LastByte) begin
          gap_cnt_d = '0;
          state_d   = (GapCycles == 0) ? StArb : StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) state_d = (|elig) ? StArb : StIdle;
        else                      gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_ch_q   <= '0;
      last_q     <= LastInit;
      byte_cnt_q <= '0;
      lat_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // RAM reads: word 0 on FETCH entry, then one prefetch per word while sending.
  always_comb begin
    rd_word   = (state_q == StSend) ? byte_cnt_q[7:4] + 1'b1 : '0;
    ts_ram_rd = ((state_q == StFetch) && (lat_cnt_q == '0)) ||
                ((state_q == StSend) && (byte_cnt_q[3:0] == PrefetchAt) &&
                 (byte_cnt_q[7:4] < LastWord));
    ts_ram_raddr = ts_ram_rd ? ts_addr_pack(cur_ch_q, ch_rd_ptr[cur_ch_q], rd_word) : '0;
  end

  // Byte stream outputs.
  always_comb begin
    ts_dout_en  = (state_q == StSend);
    ts_dout_sop = ts_dout_en && (byte_cnt_q == '0);
    ts_dout     = ts_dout_en ? shreg_q[127:120] : '0;
    ts_dout_ch  = cur_ch_q;
  end

endmodule

// File: doc/ts_merge_sched.md
TS_MERGE_SCHED -- requirements
Module: ts_merge_sched

Interface
REQ-001 Parameter: NCH, default 8, number of TS input channels sharing ts_ram.
REQ-002 Parameter: RD_LAT, default 2, fixed ts_ram read latency in clk cycles.
REQ-003 Parameter: IPG, default 4, minimum idle cycles between output packets.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 pkt_wr_done  input  NCH  per-channel one-cycle pulse: writer finished one 188-byte packet into that channel's next slot.
REQ-007 ch_en  input  NCH  per-channel enable from the config path; a disabled channel is never arbitrated.
REQ-008 ovf_clr  input  1  one-cycle pulse; clears all ovf bits.
REQ-009 ts_ram_rd  output  1  read strobe to the shared TS RAM.
REQ-010 ts_ram_raddr  output  13  read address {ch[2:0], slot[5:0], word[3:0]}.
REQ-011 ts_ram_rdata  input  128  read data, valid exactly RD_LAT cycles after ts_ram_rd.
REQ-012 ts_dout  output  8  merged TS byte stream.
REQ-013 ts_dout_en  output  1  ts_dout valid.
REQ-014 ts_dout_sop  output  1  high with byte 0 (0x47) of each packet.
REQ-015 ts_dout_ch  output  3  source channel, held for the whole packet.
REQ-016 ovf  output  NCH  sticky per-channel overflow flags.

Function
REQ-017 Each packet occupies 16 words of its slot; only words 0..11 are read; word 11 carries bytes 176..187 in bits [127:32].
REQ-018 Byte order: byte 16w+k of a packet comes from word w, bits [127-8k -: 8].
REQ-019 Per channel: 7-bit pending count (0..64) and 6-bit read slot pointer (wraps 63->0).
REQ-020 Count events: pkt_wr_done increments; the last byte (index 187) of that channel's packet decrements; both in the same cycle leave the count unchanged.
REQ-021 pkt_wr_done with count==64: count unchanged, ovf[c] set; ovf[c] stays set until ovf_clr; ovf_clr and a new overflow in the same cycle leave ovf[c] set.
REQ-022 FSM states: IDLE, ARB, FETCH, SEND, GAP.
REQ-023 IDLE -> ARB when any channel has ch_en=1 and count>0.
REQ-024 ARB (1 cycle): round-robin grant, searching from (last granted + 1) mod NCH; the reset value of last granted is NCH-1, so channel 0 wins first; latch grant into ts_dout_ch; next state FETCH.
REQ-025 FETCH: issue word 0 read at {ch, rd_ptr, 4'd0}; after RD_LAT cycles load the 128-bit shift register and go to SEND.
REQ-026 SEND: one byte per cycle, byte counter 0..187, ts_dout_en=1 throughout, ts_dout_sop=1 only at byte 0.
REQ-027 Prefetch: at byte index b with b%16==13 and b/16<11, issue a read of word b/16+1; at b%16==15, reload the shift register from ts_ram_rdata. There are no output bubbles inside a packet.
REQ-028 Byte 187: decrement count, increment rd_ptr, go to GAP.
REQ-029 GAP: IPG cycles with ts_dout_en=0, then ARB if any channel is eligible, else IDLE.
REQ-030 A packet in progress always completes, even if ch_en of its channel drops or its channel overflows mid-packet.
REQ-031 ts_ram_rd is high for exactly one cycle per issued word: 12 reads per packet, no other reads.

Reset
REQ-032 rst=0 at a clock edge: FSM->IDLE; all counts, rd_ptrs and ovf->0; ts_ram_rd, ts_dout_en, ts_dout_sop->0; ts_dout, ts_dout_ch, ts_ram_raddr->0.
REQ-033 Reset mid-packet aborts immediately; the packet is not resumed and rdata returning in flight is ignored.

Structure
REQ-034 A shared package holds TS_PKT_BYTES=188, TS_WORDS=12, SLOT_BITS=6, WORD_BITS=4, the FSM state encoding and the address-pack function.
REQ-035 One sub-module, ts_ch_cnt, implements the per-channel count, rd_ptr and ovf logic and is instantiated NCH times; the arbiter and serializer stay in the top.

Verification
REQ-036 Channel 0, one pkt_wr_done, RAM words preloaded with bytes 0x47,0x10,0x01,0x00,1..184 -> 188 contiguous ts_dout bytes identical to that sequence; ts_dout_sop on byte 0; ts_dout_ch=0; 12 reads at addresses 0x000..0x00B.
REQ-037 Channels 0, 3 and 5 each pending 2 packets -> output order 0,3,5,0,3,5; each gap of ts_dout_en=0 is exactly 4 cycles.
REQ-038 65 pkt_wr_done pulses on channel 2 with ch_en[2]=0 -> count=64, ovf[2]=1; ovf_clr -> ovf[2]=0 while count stays 64.
REQ-039 ch_en[1] cleared at byte 100 of a channel-1 packet -> the packet completes all 188 bytes; no further channel-1 packets are sent.
REQ-040 pkt_wr_done[4] in the same cycle as byte 187 of a channel-4 packet -> count unchanged; rd_ptr advances by 1.
REQ-041 rst=0 at byte 50 -> next cycle ts_dout_en=0 and ts_ram_rd=0; after release, no output until a new pkt_wr_done.
